// File: rtl/mt_wr_source_pkg.sv
// Shared types and constants for the mock-turtle to White Rabbit fabric TX bridge.
package mt_wr_source_pkg;

  localparam logic [1:0] c_WRF_DATA = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_GAP,
    S_WAIT_ACK,
    S_DROP
  } t_mt_wr_src_state;

  typedef struct packed {
    logic        last;
    logic        half;
    logic [31:0] data;
  } t_mt_wr_src_fifo_entry;

endpackage

// File: rtl/mt_wr_source_fifo.sv
// Synchronous FIFO with registered ready (= not full) and an occupancy level output.
module mt_wr_source_fifo #(
  parameter int unsigned g_depth = 16,
  parameter int unsigned g_width = 33
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [g_width-1:0]         d_i,
  output logic [g_width-1:0]         q_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ready_o,
  output logic [$clog2(g_depth):0]   level_o
);

  localparam int unsigned c_AW = $clog2(g_depth);

  logic [g_width-1:0] r_mem [g_depth];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_AW:0]      r_count;
  logic [c_AW:0]      w_count_next;
  logic               r_ready;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (r_count == (c_AW+1)'(g_depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign q_o     = r_mem[r_rd_ptr];
  assign ready_o = r_ready;
  assign level_o = r_count;

  always_comb begin
    w_count_next = r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      // ready tracks the occupancy the FIFO will have after this edge
      r_ready <= (w_count_next != (c_AW+1)'(g_depth));
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= d_i;
  end

endmodule

// File: rtl/mt_wr_source.sv
// MT stream (32-bit words, last-delimited) to 16-bit pipelined Wishbone WR fabric framer.
// Optional MT_WR_SOURCE_ODD_HALF_EN adds snk_half_i: a last word flagged half sends only its upper beat.
module mt_wr_source
  import mt_wr_source_pkg::*;
#(
  parameter int unsigned g_fifo_depth      = 16,
  parameter int unsigned g_max_outstanding = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] snk_data_i,
  input  logic        snk_valid_i,
  input  logic        snk_last_i,
`ifdef MT_WR_SOURCE_ODD_HALF_EN
  input  logic        snk_half_i,
`endif
  output logic        snk_ready_o,
  output logic        src_cyc_o,
  output logic        src_stb_o,
  output logic        src_we_o,
  output logic [1:0]  src_sel_o,
  output logic [1:0]  src_adr_o,
  output logic [15:0] src_dat_o,
  input  logic        src_stall_i,
  input  logic        src_ack_i,
  input  logic        src_err_i,
  input  logic        src_rty_i,
  output logic [15:0] tx_frames_o,
  output logic [15:0] tx_errors_o
);

  localparam int unsigned c_OW = $clog2(g_max_outstanding + 1);
  localparam int unsigned c_LW = $clog2(g_fifo_depth) + 1;
`ifdef MT_WR_SOURCE_ODD_HALF_EN
  localparam int unsigned c_EW = 34;
`else
  localparam int unsigned c_EW = 33;
`endif

  t_mt_wr_src_state      r_state;
  t_mt_wr_src_state      w_next;
  t_mt_wr_src_fifo_entry w_head;
  logic [c_EW-1:0]       w_fifo_d;
  logic [c_EW-1:0]       w_fifo_q;
  logic [c_LW-1:0]       w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic [c_OW-1:0]       r_outst;
  logic [15:0]           r_tx_frames;
  logic [15:0]           r_tx_errors;
  logic                  w_cyc;
  logic                  w_stb;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_err;
  logic                  w_frame_done;
  logic                  w_unused;

`ifdef MT_WR_SOURCE_ODD_HALF_EN
  assign w_fifo_d = {snk_last_i, snk_half_i, snk_data_i};
  assign w_head   = '{last: w_fifo_q[33], half: w_fifo_q[32], data: w_fifo_q[31:0]};
`else
  assign w_fifo_d = {snk_last_i, snk_data_i};
  assign w_head   = '{last: w_fifo_q[32], half: 1'b0, data: w_fifo_q[31:0]};
`endif

  assign w_push   = snk_valid_i && w_ready;
  assign w_unused = ^{src_rty_i, w_full};

  mt_wr_source_fifo #(
    .g_depth (g_fifo_depth),
    .g_width (c_EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .d_i     (w_fifo_d),
    .q_o     (w_fifo_q),
    .full_o  (w_full),
    .empty_o (w_empty),
    .ready_o (w_ready),
    .level_o (w_level)
  );

  assign w_cyc    = (r_state == S_HI) || (r_state == S_LO) ||
                    (r_state == S_GAP) || (r_state == S_WAIT_ACK);
  assign w_stb    = ((r_state == S_HI) || (r_state == S_LO)) &&
                    (r_outst != c_OW'(g_max_outstanding));
  assign w_accept = w_stb && !src_stall_i;
  assign w_ack    = w_cyc && src_ack_i;
  assign w_err    = w_cyc && src_err_i;

  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:     if (!w_empty) w_next = S_HI;
      S_HI: begin
        if (w_accept) begin
          if (w_head.last && w_head.half) begin
            w_pop  = 1'b1;
            w_next = S_WAIT_ACK;
          end else begin
            w_next = S_LO;
          end
        end
      end
      S_LO: begin
        if (w_accept) begin
          w_pop = 1'b1;
          // level still counts the word being popped, so >1 means a follow-up word exists
          if (w_head.last)              w_next = S_WAIT_ACK;
          else if (w_level > c_LW'(1))  w_next = S_HI;
          else                          w_next = S_GAP;
        end
      end
      S_GAP:      if (!w_empty) w_next = S_HI;
      S_WAIT_ACK: begin
        if (r_outst == '0) begin
          w_frame_done = 1'b1;
          w_next       = S_IDLE;
        end
      end
      S_DROP: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head.last) w_next = S_IDLE;
        end
      end
      default:    w_next = S_IDLE;
    endcase
    if (w_err) begin
      w_pop        = 1'b0;
      w_frame_done = 1'b0;
      w_next       = (r_state == S_WAIT_ACK) ? S_IDLE : S_DROP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_outst     <= '0;
      r_tx_frames <= '0;
      r_tx_errors <= '0;
    end else begin
      r_state <= w_next;
      if (w_err)
        r_outst <= '0;
      else if (w_accept && !(w_ack && r_outst != '0))
        r_outst <= r_outst + 1'b1;
      else if (!w_accept && w_ack && r_outst != '0)
        r_outst <= r_outst - 1'b1;
      if (w_frame_done) r_tx_frames <= r_tx_frames + 16'd1;
      if (w_err)        r_tx_errors <= r_tx_errors + 16'd1;
    end
  end

  always_comb begin
    src_dat_o = '0;
    if (r_state == S_HI)      src_dat_o = w_head.data[31:16];
    else if (r_state == S_LO) src_dat_o = w_head.data[15:0];
  end

  assign snk_ready_o = w_ready;
  assign src_cyc_o   = w_cyc;
  assign src_stb_o   = w_stb;
  assign src_we_o    = 1'b1;
  assign src_sel_o   = 2'b11;
  assign src_adr_o   = c_WRF_DATA;
  assign tx_frames_o = r_tx_frames;
  assign tx_errors_o = r_tx_errors;

endmodule

// File: doc/mt_wr_source.md
Name: mt_wr_source

Overview:
- TX counterpart of mt_wr_sink. Sits between the mock-turtle CPU/stream side and the White Rabbit fabric.
- Accepts 32-bit MT stream words, frames each packet (stream `last` delimits it) and emits it as a 16-bit pipelined Wishbone WR fabric frame.
- Buffers stream words in a small FIFO and tracks outstanding acks so `cyc` closes only after the whole frame is acknowledged.
- Aborts cleanly on fabric `err`.

Parameters:
- g_fifo_depth, 16: input word FIFO depth in 32-bit words; power of 2, minimum 4.
- g_max_outstanding, 15: max strobes in flight without ack; sets outstanding counter width (4 bits).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- snk_data_i  in  32  stream word; bits 31:16 go on the wire first
- snk_valid_i  in  1  stream word valid
- snk_last_i  in  1  word is the last of the packet
- snk_ready_o  out  1  FIFO can accept a word; transfer occurs when valid and ready are both 1
- src_cyc_o  out  1  fabric cycle
- src_stb_o  out  1  fabric strobe
- src_we_o  out  1  always 1
- src_sel_o  out  2  always "11"
- src_adr_o  out  2  "00" for data beats
- src_dat_o  out  16  fabric data
- src_stall_i  in  1  fabric stall
- src_ack_i  in  1  fabric ack
- src_err_i  in  1  fabric error
- src_rty_i  in  1  ignored
- tx_frames_o  out  16  frames completed OK; wraps at 0xFFFF
- tx_errors_o  out  16  frames aborted on err; wraps

Behaviour:
- **Clocking and reset:** single clock domain; reset is synchronous, active-low on rst_n_i.
- **Reset values:**
  - all src_* outputs 0, except src_we_o=1 and src_sel_o="11"
  - snk_ready_o=0 while reset is asserted
  - counters 0; FIFO empty
- **FIFO:**
  - Stores {last, data}.
  - snk_ready_o = not full, registered.
  - Simultaneous push and pop when full is not allowed: ready is already 0.
- **FSM states:**
  - IDLE: waits for FIFO non-empty. Then assert cyc, go to HI. Cyc rises 1 cycle after the first word is visible at the FIFO head.
  - HI: stb=1, dat=word[31:16]. When not stall, go to LO.
  - LO: stb=1, dat=word[15:0]. When not stall, pop the word.
    - If last, go to WAIT_ACK.
    - Else if FIFO non-empty, go to HI.
    - Else go to GAP.
  - GAP: stb=0, cyc held; when FIFO non-empty, go to HI.
  - WAIT_ACK: stb=0; when outstanding==0, drop cyc, increment tx_frames_o, go to IDLE.
  - DROP: cyc=0, stb=0; pop and discard words until a word with last is popped, then go to IDLE.
- **Throughput:** 2 fabric beats per stream word, back-to-back when not stalled.
- **Outstanding counter:**
  - +1 per accepted strobe (stb and not stall); -1 per ack; both in the same cycle = no change.
  - When the counter equals g_max_outstanding, stb is held 0 until an ack arrives.
- **err (any state with cyc=1):**
  - Next cycle cyc=0, stb=0, increment tx_errors_o, clear outstanding.
  - If last has already been popped, go to IDLE; else go to DROP.
- **Spurious inputs:** ack or err with cyc=0 is ignored.
- **Reset mid-frame:** cyc drops at the next edge; FIFO contents are discarded; no counter increments.
- **Empty packet:** impossible; every word carries data.

Optional Feature:
- Macro: MT_WR_SOURCE_ODD_HALF_EN.
- **Defined:**
  - Adds port snk_half_i (in, 1), sampled with last.
  - If half=1 on the last word, only the HI beat is sent; LO is skipped and the FSM goes straight to WAIT_ACK.
  - FIFO entry width becomes 34 bits.
- **Not defined:** the port is absent; every word produces 2 beats.

Decomposition:
- Package mt_wr_source_pkg:
  - c_WRF_DATA="00"
  - FSM state enum
  - record t_mt_wr_src_fifo_entry {last, half, data}
- One sub-module: mt_wr_source_fifo, a synchronous FIFO with generic depth and width, providing full, empty and registered ready.

Test Plan:
1. **Single packet, no stall:** 3 words 0x11112222, 0x33334444, 0x55556666 (last on the third).
   - Expect dat beats 1111,2222,3333,4444,5555,6666 on 6 consecutive cycles, adr=00.
   - Expect cyc to drop after the 6th ack; tx_frames_o=1.
2. **Stall toggling:** assert stall every other cycle on a 100-word packet.
   - Expect 200 beats, in order, with no duplication; data unchanged while stalled.
3. **Ack delay:** hold ack for 20 cycles, then release.
   - Expect stb to stall once 15 strobes are outstanding.
   - Expect cyc to stay high until all 200 acks are received.
4. **err mid-frame:** pulse err on beat 10 of a 50-word packet, then send a 4-word packet.
   - Expect tx_errors_o=1 and the remainder of the first packet dropped.
   - Expect the 4-word packet to be sent intact; tx_frames_o=1.
5. **FIFO full back-pressure:** hold stall for 40 cycles while pushing 20 words.
   - Expect snk_ready_o=0 after 16 words are buffered; no words lost.
6. **Odd-half (macro defined):** 2 words, last with half=1, data 0xAAAABBBB, 0xCCCCDDDD.
   - Expect beats AAAA,BBBB,CCCC only.
